spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 44 ++++
 rtl/spi_slave.sv | 197 +++++++++++++++++++
 tb/tb_spi_slave.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared constants for the SPI slave block: FSM state
//               encoding and the default serial word length.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Default serial word length in bits.
    localparam int c_default_width = 8;

    // FSM state encoding.
    localparam int         c_state_w    = 1;
    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_active  = 1'b1;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Two-flop synchronizer for an asynchronous input followed by
//               a rising/falling edge detector on the synchronized level.
// Ports       : clk, rst (async, active-high)
//               d     - asynchronous input
//               rise  - one-cycle pulse on a synchronized 0->1 transition
//               fall  - one-cycle pulse on a synchronized 1->0 transition
// Parameters  : RESET_VAL - value all flops take during reset, chosen as the
//               idle level of the line so that reset produces no edge.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise = r_sync & ~r_prev;
    assign fall = ~r_sync & r_prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI mode-0, MSB-first slave with a system-clock domain
//               parallel interface. sck, cs_n and mosi are oversampled
//               (clk >= 4x sck) through two-flop synchronizers.
// Ports       : clk, rst (async, active-high)
//               sck, cs_n, mosi  - SPI inputs from the master
//               miso, miso_oe    - SPI output and its enable
//               tx_data/tx_valid/tx_ready - next word to transmit
//               rx_data/rx_valid/rx_ready - last received word
//               overrun          - sticky receive-overrun flag
// Config      : define SPI_SLAVE_OVERRUN_EN to enable overrun detection;
//               otherwise overrun is tied low and overwrites are silent.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    logic                  w_sck_rise;
    logic                  w_sck_fall;
    logic                  w_cs_rise;
    logic                  w_cs_fall;
    logic                  r_mosi_meta;
    logic                  r_mosi_sync;

    logic [c_state_w-1:0]  r_state;
    logic [c_state_w-1:0]  w_state_nxt;

    logic [c_cnt_w-1:0]    r_cnt;
    logic [WIDTH-1:0]      r_rx_sh;
    logic [WIDTH-1:0]      r_tx_sh;
    logic                  r_load_pend;
    logic [WIDTH-1:0]      r_rx_data;
    logic                  r_rx_valid;

    logic                  w_active;
    logic                  w_enter;
    logic                  w_leave;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_load;
    logic                  w_wrap;
    logic [WIDTH-1:0]      w_rx_word;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sck),
        .rise (w_sck_rise),
        .fall (w_sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n),
        .rise (w_cs_rise),
        .fall (w_cs_fall)
    );

    // mosi shares the sck pipeline depth, so the sample taken on a detected
    // sck rise is the bit the master presented at that rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (w_cs_fall) w_state_nxt = c_st_active;
            c_st_active: if (w_cs_rise) w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------- event decode
    assign w_active  = (r_state == c_st_active);
    assign w_enter   = (r_state == c_st_idle) & w_cs_fall;
    assign w_leave   = w_active & w_cs_rise;
    // A deselect takes priority over any sck edge seen in the same cycle.
    assign w_rise    = w_active & ~w_cs_rise & w_sck_rise;
    assign w_fall    = w_active & ~w_cs_rise & w_sck_fall;
    assign w_load    = w_enter | (w_fall & r_load_pend);
    assign w_wrap    = w_rise & (r_cnt == c_last);
    assign w_rx_word = {r_rx_sh[WIDTH-2:0], r_mosi_sync};

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_load_pend <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            if (w_enter || w_leave) begin
                // Fresh selection or deselect: drop any partial word.
                r_cnt       <= '0;
                r_rx_sh     <= '0;
                r_load_pend <= 1'b0;
            end else begin
                if (w_rise) begin
                    r_rx_sh <= w_rx_word;
                    r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
                    if (w_wrap) begin
                        r_load_pend <= 1'b1;
                    end
                end
                if (w_fall && r_load_pend) begin
                    r_load_pend <= 1'b0;
                end
            end

            // Underrun sends all-ones so the master sees an idle-high line.
            if (w_load) begin
                r_tx_sh <= tx_valid ? tx_data : '1;
            end else if (w_fall) begin
                r_tx_sh <= r_tx_sh << 1;
            end

            if (w_wrap) begin
                r_rx_data <= w_rx_word;
            end

            // A completing word wins over a same-cycle consume.
            if (w_wrap) begin
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_wrap && r_rx_valid && !rx_ready) begin
            r_overrun <= 1'b1;
        end else if (w_enter) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

    assign miso     = w_active ? r_tx_sh[WIDTH-1] : 1'b0;
    assign miso_oe  = w_active;
    assign tx_ready = w_load & tx_valid;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule : spi_slave
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Self-checking bench for spi_slave (WIDTH=8). A bench-side
//               mode-0 master drives sck/cs_n/mosi; a producer feeds the tx
//               interface from a queue; received words are scoreboarded.
//               Honours SPI_SLAVE_OVERRUN_EN for the overrun expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int c_w    = 8;
    localparam int c_half = 6;   // sck half period in clk cycles

    logic           clk = 1'b0;
    logic           rst;
    logic           sck;
    logic           cs_n;
    logic           mosi;
    logic           miso;
    logic           miso_oe;
    logic [c_w-1:0] tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [c_w-1:0] rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic           overrun;

    int             total = 0;
    int             bad   = 0;
    int             n_take = 0;
    bit             mon_en = 1'b1;
    logic [c_w-1:0] tx_q[$];
    logic [c_w-1:0] exp_rx[$];
    logic [c_w-1:0] exp_miso[$];

`ifdef SPI_SLAVE_OVERRUN_EN
    localparam logic c_ovr_exp = 1'b1;
`else
    localparam logic c_ovr_exp = 1'b0;
`endif

    spi_slave #(.WIDTH(c_w)) dut (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tx_refresh();
        tx_valid = (tx_q.size() != 0);
        tx_data  = (tx_q.size() != 0) ? tx_q[0] : '0;
    endtask

    // Producer: a word is taken at the clk edge that ends a tx_ready cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                n_take++;
                @(posedge clk);
                #1;
                if (tx_q.size() != 0) void'(tx_q.pop_front());
                tx_refresh();
            end
        end
    end

    // Receive monitor: each new rx_valid assertion must match the next
    // expected word.
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && rx_valid === 1'b1 && !prev_v) begin
                check("rx_expected_pending", 32'(exp_rx.size() != 0), 32'd1);
                if (exp_rx.size() != 0) check("rx_word", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
            prev_v = (rx_valid === 1'b1);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode-0 master: mosi presented while sck is low, miso sampled just
    // before the rising edge.
    task automatic xfer(input logic [c_w-1:0] mo, input int nbits, output logic [c_w-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[c_w-1-i];
            wait_clks(c_half);
            mi = {mi[c_w-2:0], miso};
            sck = 1'b1;
            wait_clks(c_half);
            sck = 1'b0;
        end
    endtask

    task automatic send_word(input logic [c_w-1:0] mo, input logic [c_w-1:0] exp_mi);
        logic [c_w-1:0] mi;
        if (mon_en) exp_rx.push_back(mo);
        exp_miso.push_back(exp_mi);
        xfer(mo, c_w, mi);
        check("miso_word", 32'(mi), 32'(exp_miso.pop_front()));
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        wait_clks(8);
    endtask

    task automatic frame_end();
        wait_clks(c_half);
        cs_n = 1'b1;
        wait_clks(10);
    endtask

    initial begin
        int             t0;
        logic [c_w-1:0] dummy;

        rst = 1'b1; sck = 1'b0; cs_n = 1'b0; mosi = 1'b0; rx_ready = 1'b1;
        tx_refresh();

        // Reset held while the master is selected and clocking.
        for (int i = 0; i < 10; i++) begin
            wait_clks(2);
            sck = ~sck;
            mosi = ~mosi;
        end
        check("rst_miso",     32'(miso),     32'd0);
        check("rst_miso_oe",  32'(miso_oe),  32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_overrun",  32'(overrun),  32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(6);
        check("idle_miso_oe", 32'(miso_oe), 32'd0);

        // Single word.
        tx_q.push_back(8'hA5); tx_refresh();
        t0 = n_take;
        frame_begin();
        check("active_miso_oe", 32'(miso_oe), 32'd1);
        send_word(8'h3C, 8'hA5);
        frame_end();
        check("single_tx_ready_pulses", 32'(n_take - t0), 32'd1);
        check("single_rx_data", 32'(rx_data), 32'h3C);
        check("idle_miso", 32'(miso), 32'd0);

        // Back-to-back words in one frame.
        tx_q.push_back(8'h01); tx_q.push_back(8'h80); tx_refresh();
        t0 = n_take;
        frame_begin();
        send_word(8'h01, 8'h01);
        send_word(8'h80, 8'h80);
        frame_end();
        check("b2b_tx_ready_pulses", 32'(n_take - t0), 32'd2);
        check("b2b_rx_data", 32'(rx_data), 32'h80);

        // Underrun.
        t0 = n_take;
        frame_begin();
        send_word(8'hC3, 8'hFF);
        frame_end();
        check("underrun_tx_ready_pulses", 32'(n_take - t0), 32'd0);

        // Abort after 5 bits.
        frame_begin();
        xfer(8'hE7, 5, dummy);
        frame_end();
        check("abort_rx_valid", 32'(rx_valid), 32'd0);
        check("abort_rx_data",  32'(rx_data),  32'hC3);
        frame_begin();
        send_word(8'h5A, 8'hFF);
        frame_end();
        check("after_abort_rx_data", 32'(rx_data), 32'h5A);

        // Overrun: two words while the consumer is stalled.
        mon_en = 1'b0; rx_ready = 1'b0;
        frame_begin();
        send_word(8'h11, 8'hFF);
        send_word(8'h22, 8'hFF);
        frame_end();
        check("ovr_rx_data",  32'(rx_data),  32'h22);
        check("ovr_rx_valid", 32'(rx_valid), 32'd1);
        check("ovr_flag",     32'(overrun),  32'(c_ovr_exp));
        rx_ready = 1'b1;
        wait_clks(1);
        check("ovr_consume_rx_valid", 32'(rx_valid), 32'd0);
        check("ovr_flag_sticky",      32'(overrun),  32'(c_ovr_exp));
        mon_en = 1'b1;
        frame_begin();
        check("ovr_cleared_on_cs_fall", 32'(overrun), 32'd0);
        frame_end();

        check("rx_scoreboard_drained", 32'(exp_rx.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_slave
`default_nettype wire
